// File: rtl/regfile_dbg_pkg.sv
// Shared types and widths for the debug register-file access block.
package regfile_dbg_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ACCESS,
    RESP,
    HOLD
  } dbg_state_e;
endpackage

// File: rtl/regfile_port_mux.sv
// Selects whether the register-file write and rs1 ports are driven by the core or by debug.
module regfile_port_mux
  import regfile_dbg_pkg::*;
(
  input  logic              own_debug_i,
  input  logic [REG_AW-1:0] core_rs1_addr_i,
  input  logic [REG_AW-1:0] core_rd_addr_i,
  input  logic              core_rd_wren_i,
  input  logic [XLEN-1:0]   core_rd_data_i,
  input  logic [REG_AW-1:0] dbg_addr_i,
  input  logic              dbg_write_i,
  input  logic [XLEN-1:0]   dbg_wdata_i,
  output logic [REG_AW-1:0] rf_rs1_addr_o,
  output logic [REG_AW-1:0] rf_rd_addr_o,
  output logic              rf_rd_wren_o,
  output logic [XLEN-1:0]   rf_rd_data_o
);

  always_comb begin
    if (own_debug_i) begin
      rf_rs1_addr_o = dbg_addr_i;
      rf_rd_addr_o  = dbg_addr_i;
      rf_rd_wren_o  = dbg_write_i;
      rf_rd_data_o  = dbg_wdata_i;
    end else begin
      rf_rs1_addr_o = core_rs1_addr_i;
      rf_rd_addr_o  = core_rd_addr_i;
      rf_rd_wren_o  = core_rd_wren_i;
      rf_rd_data_o  = core_rd_data_i;
    end
  end

endmodule

// File: rtl/regfile_dbg_access.sv
// Debug initiator for the GPR file: halts the core, performs one read/write, returns a response.
// Optional macro REGFILE_DBG_HALT_HOLD_EN keeps the core halted for HOLD_CYCLES after each response.
//
// state  | meaning
// IDLE   | transparent, ready for a request
// HALT   | halt_req raised, waiting for halt_ack or timeout
// ACCESS | debug owns rf ports for one cycle
// RESP   | response presented until rsp_ready
// HOLD   | core kept halted, back-to-back requests accepted
module regfile_dbg_access
  import regfile_dbg_pkg::*;
#(
  parameter int unsigned HALT_TIMEOUT = 64,
  parameter int unsigned HOLD_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [REG_AW-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              halt_req,
  input  logic              halt_ack,
  input  logic [REG_AW-1:0] core_rs1_addr,
  input  logic [REG_AW-1:0] core_rd_addr,
  input  logic              core_rd_wren,
  input  logic [XLEN-1:0]   core_rd_data,
  output logic [REG_AW-1:0] rf_rs1_addr,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic              rf_rd_wren,
  output logic [XLEN-1:0]   rf_rd_data,
  input  logic [XLEN-1:0]   rf_rs1_data
);

  localparam logic [7:0] HALT_LIM = 8'(HALT_TIMEOUT);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);

  dbg_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic [7:0]        cnt_inc;
  logic [7:0]        cnt_lim;

  assign req_ready = (state_q == IDLE) || (state_q == HOLD);
  assign rsp_valid = (state_q == RESP);
  assign halt_req  = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept  = req_valid && req_ready;
  assign cnt_inc = cnt_q + 8'd1;
  // One counter serves both the halt timeout and the post-response hold window.
  assign cnt_lim = (state_q == HOLD) ? HOLD_LIM : HALT_LIM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        if (halt_ack) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == cnt_lim) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        rdata_d = write_q ? '0 : rf_rs1_data;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
`ifdef REGFILE_DBG_HALT_HOLD_EN
          cnt_d   = '0;
          state_d = HOLD;
`else
          state_d = IDLE;
`endif
        end
      end
      HOLD: begin
`ifdef REGFILE_DBG_HALT_HOLD_EN
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = halt_ack ? ACCESS : HALT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == cnt_lim) state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  regfile_port_mux u_mux (
    .own_debug_i     (state_q == ACCESS),
    .core_rs1_addr_i (core_rs1_addr),
    .core_rd_addr_i  (core_rd_addr),
    .core_rd_wren_i  (core_rd_wren),
    .core_rd_data_i  (core_rd_data),
    .dbg_addr_i      (addr_q),
    .dbg_write_i     (write_q),
    .dbg_wdata_i     (wdata_q),
    .rf_rs1_addr_o   (rf_rs1_addr),
    .rf_rd_addr_o    (rf_rd_addr),
    .rf_rd_wren_o    (rf_rd_wren),
    .rf_rd_data_o    (rf_rd_data)
  );

endmodule

// File: tb/tb_regfile_dbg_access.sv
// Self-checking bench for regfile_dbg_access with an attached GPR file and a reference register array.
module tb_regfile_dbg_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        halt_req;
  logic        halt_ack = 1'b1;
  logic [4:0]  core_rs1_addr = '0;
  logic [4:0]  core_rd_addr = '0;
  logic        core_rd_wren = 1'b0;
  logic [31:0] core_rd_data = '0;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rd_addr;
  logic        rf_rd_wren;
  logic [31:0] rf_rd_data;
  logic [31:0] rf_rs1_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wren_count = 0;

  logic [31:0] env_rf [32] = '{default: 32'h0};
  logic [31:0] ref_rf [32];

  always #5 clk = ~clk;

  regfile_dbg_access #(.HALT_TIMEOUT(TO), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .core_rs1_addr(core_rs1_addr), .core_rd_addr(core_rd_addr),
    .core_rd_wren(core_rd_wren), .core_rd_data(core_rd_data),
    .rf_rs1_addr(rf_rs1_addr), .rf_rd_addr(rf_rd_addr), .rf_rd_wren(rf_rd_wren),
    .rf_rd_data(rf_rd_data), .rf_rs1_data(rf_rs1_data)
  );

  // Register file the block sits in front of: x0 reads zero, writes land at the clock edge.
  assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'h0 : env_rf[rf_rs1_addr];
  always @(posedge clk) begin
    if (rf_rd_wren && rf_rd_addr != 5'd0) env_rf[rf_rd_addr] <= rf_rd_data;
  end

  always @(negedge clk) begin
    if (rf_rd_wren) wren_count++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic core_write(input logic [4:0] a, input logic [31:0] d);
    core_rd_addr = a;
    core_rd_data = d;
    core_rd_wren = 1'b1;
    @(posedge clk);
    #1 core_rd_wren = 1'b0;
    if (a != 5'd0) ref_rf[a] = d;
  endtask

  // Starts at posedge+1. With rr=1 returns at posedge+1 after the response handshake;
  // with rr=0 returns at the negedge where rsp_valid was first seen.
  task automatic dbg_txn(input logic w, input logic [4:0] a, input logic [31:0] d, input logic rr,
                         output logic [31:0] rdata, output logic err, output int lat);
    int k;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    rsp_ready = rr;
    rdata = 'x;
    err   = 'x;
    lat   = -1;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      expire("accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) begin
      expire("response");
      return;
    end
    lat   = k;
    rdata = rsp_rdata;
    err   = rsp_err;
    if (rr) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w0;
    logic [31:0] held;
    logic        ok;

    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;

    #2;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_halt_req", {31'b0, halt_req}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    core_write(5'd5, 32'hDEADBEEF);

    tbl[0] = '{1'b0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 5'd10, 32'h12345678, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 5'd10, 32'h0,        32'h12345678, 1'b0};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b0};
    tbl[5] = '{1'b1, 5'd31, 32'hA5A50F0F, 32'h0,        1'b0};
    tbl[6] = '{1'b0, 5'd31, 32'h0,        32'hA5A50F0F, 1'b0};
    tbl[7] = '{1'b0, 5'd10, 32'h0,        32'h12345678, 1'b0};

    halt_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dbg_txn(tbl[i].w, tbl[i].a, tbl[i].d, 1'b1, rd, er, lat);
      if (tbl[i].w && tbl[i].a != 5'd0) ref_rf[tbl[i].a] = tbl[i].d;
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_latency", i), lat, 32'd3);
      @(negedge clk);
      chk($sformatf("tbl%0d_halt_released", i), {31'b0, halt_req}, 32'd0);
      @(posedge clk);
      #1;
    end

    core_rs1_addr = 5'd10;
    @(negedge clk);
    chk("core_rs1_x10", rf_rs1_data, 32'h12345678);
    @(posedge clk);
    #1;

    // Halt never acknowledged: error after TO cycles of HALT, no register-file write.
    halt_ack = 1'b0;
    w0 = wren_count;
    dbg_txn(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, rd, er, lat);
    chk("timeout_err", {31'b0, er}, 32'd1);
    chk("timeout_rdata", rd, 32'd0);
    chk("timeout_latency", lat, TO + 1);
    chk("timeout_no_wren", wren_count - w0, 32'd0);
    @(negedge clk);
    chk("timeout_halt_released", {31'b0, halt_req}, 32'd0);
    @(posedge clk);
    #1 halt_ack = 1'b1;
    dbg_txn(1'b0, 5'd7, 32'h0, 1'b1, rd, er, lat);
    chk("timeout_x7_untouched", rd, ref_rf[7]);

    // Backpressure then reset while the response is pending.
    dbg_txn(1'b0, 5'd5, 32'h0, 1'b0, rd, er, lat);
    chk("bp_first_rdata", rd, 32'hDEADBEEF);
    held = rd;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== held || !halt_req) ok = 1'b0;
    end
    chk("bp_stable_10_cycles", {31'b0, ok}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mid_halt_req", {31'b0, halt_req}, 32'd0);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;

    // Random mix of core writes and debug accesses against the reference array.
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [4:0]  a;
      logic [31:0] d;
      op = $urandom_range(0, 2);
      a  = 5'($urandom_range(0, 31));
      d  = $urandom;
      if (op == 0) begin
        core_write(a, d);
      end else begin
        logic [31:0] exp;
        exp = (op == 2) ? ref_rf[a] : 32'h0;
        dbg_txn(op == 1, a, d, 1'b1, rd, er, lat);
        if (op == 1 && a != 5'd0) ref_rf[a] = d;
        chk($sformatf("rnd%0d_rdata", i), rd, exp);
        chk($sformatf("rnd%0d_err", i), {31'b0, er}, 32'd0);
        chk($sformatf("rnd%0d_latency", i), lat, 32'd3);
      end
    end

    // Transparency: idle block passes core traffic straight through.
    for (int i = 0; i < 100; i++) begin
      core_rs1_addr = 5'($urandom);
      core_rd_addr  = 5'($urandom);
      core_rd_wren  = 1'($urandom);
      core_rd_data  = $urandom;
      @(negedge clk);
      chk($sformatf("pass%0d", i),
          {rf_rs1_addr, rf_rd_addr, rf_rd_wren, rf_rd_data[20:0]},
          {core_rs1_addr, core_rd_addr, core_rd_wren, core_rd_data[20:0]});
      chk($sformatf("pass%0d_data", i), rf_rd_data, core_rd_data);
      @(posedge clk);
      if (core_rd_wren && core_rd_addr != 5'd0) ref_rf[core_rd_addr] = core_rd_data;
      #1;
    end
    core_rd_wren = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_dbg_access.md
Name: regfile_dbg_access

Overview:
Debug-side initiator for the 32x32 integer register file (x0 hardwired zero, combinational read, synchronous write). Accepts single read/write requests from the debug transport over a valid/ready pair and asks the core to halt. Once halted, it takes over the register-file rs1 and rd ports from the core for one cycle, then returns a response. Sits between the core datapath and the register file; when idle it is a transparent mux.

Parameters:
HALT_TIMEOUT, 64, cycles to wait for halt_ack before failing the request with error; range 1..255
HOLD_CYCLES, 8, cycles halt stays asserted after a response (used only with the optional feature); range 1..255

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  debug request valid
req_ready  output  1  request accepted when req_valid and req_ready are both high
req_write  input  1  1 = write GPR, 0 = read GPR
req_addr  input  5  GPR index
req_wdata  input  32  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high
rsp_rdata  output  32  read data; 0 for writes and errors
rsp_err  output  1  1 = halt timeout, no access performed
halt_req  output  1  request that the core stop issuing register-file accesses
halt_ack  input  1  core is quiesced
core_rs1_addr  input  5  core rs1 address
core_rd_addr  input  5  core rd address
core_rd_wren  input  1  core write enable
core_rd_data  input  32  core write data
rf_rs1_addr  output  5  to regfile rs1_addr
rf_rd_addr  output  5  to regfile rd_addr
rf_rd_wren  output  1  to regfile rd_wren
rf_rd_data  output  32  to regfile rd_data
rf_rs1_data  input  32  from regfile rs1_data

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, halt_req=0, timeout counter=0, request registers=0. The rf_* ports pass the core_* signals through.
- States: IDLE, HALT, ACCESS, RESP (plus HOLD with the optional feature).
- IDLE: req_ready=1. On a handshake, latch write/addr/wdata, set halt_req=1, clear the counter, go to HALT.
- HALT: req_ready=0, halt_req=1. Each cycle:
  - if halt_ack=1, go to ACCESS;
  - else increment the counter; when it reaches HALT_TIMEOUT, go to RESP with rsp_err=1 and no register-file access.
  - An ack arriving on the same cycle as the final count wins: go to ACCESS.
- ACCESS (exactly 1 cycle): the rf_* ports are owned by this block.
  - rf_rs1_addr = latched addr; rf_rd_addr = latched addr; rf_rd_wren = latched write.
  - Read: capture rf_rs1_data into rsp_rdata.
  - Write: rsp_rdata=0. A write to x0 is issued; the register file ignores it, and rsp_err=0.
  - Go to RESP.
- RESP: rsp_valid=1 and held stable until rsp_ready. On the handshake: rsp_valid=0, halt_req=0, go to IDLE.
- The rf_* ports follow core_* in every state except ACCESS. While halted the core is required to keep core_rd_wren=0, so no write is lost.
- Latency (ack on the first HALT cycle, rsp_ready=1): accept at cycle 0, response valid at cycle 3.
- Read-after-write by two back-to-back requests returns the new value, because the write commits at the end of ACCESS.
- halt_ack dropping mid-ACCESS or mid-RESP is ignored; the access still completes.
- Reset mid-operation: immediate return to reset values, halt_req drops, any pending response is discarded.

Optional Feature:
- Macro REGFILE_DBG_HALT_HOLD_EN.
- Defined: after the RESP handshake, go to HOLD instead of IDLE.
  - HOLD keeps halt_req=1 and req_ready=1, and counts up to HOLD_CYCLES.
  - A request accepted in HOLD goes straight to ACCESS if halt_ack=1, otherwise to HALT.
  - When the count expires, halt_req=0 and the FSM goes to IDLE.
- Undefined: no HOLD state; the halt is released after every response.

Decomposition:
- Package regfile_dbg_pkg: enum type dbg_state_e {IDLE, HALT, ACCESS, RESP, HOLD}; constants XLEN=32, REG_AW=5.
- Sub-module regfile_port_mux: combinational core/debug selection of the rf_* ports, keyed by an own_debug signal (high only in ACCESS).

Test Plan:
- Read: write x5 = 0xDEADBEEF via the core, then a debug read of x5 with halt_ack tied 1 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at cycle 3.
- Write: debug write x10 = 0x12345678, then a debug read of x10 -> 0x12345678; core rs1_data for x10 also reads 0x12345678 after release.
- x0: debug write x0 = 0xFFFFFFFF, then read x0 -> rsp_rdata=0, rsp_err=0.
- Timeout: halt_ack held 0, HALT_TIMEOUT=4 -> rsp_err=1 after 4 HALT cycles, rsp_rdata=0, no rf_rd_wren pulse, halt_req drops after the response.
- Backpressure and reset: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_rdata stable, halt_req stays 1; assert rst during RESP -> all outputs return to reset values on the same cycle.
- Transparency: with no requests, random core_* traffic -> rf_* equals core_* every cycle.
